// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter (define UART_ARB_PRIORITY_EN for fixed priority on requester 0)
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 64
) (
  input  logic                         SysClk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
  output logic [NUM_REQ-1:0]           Ack,
  input  logic                         Tx_Busy,
  input  logic                         BIST_Busy,
  output logic [DATA_BITS-1:0]         Tx_Data,
  output logic                         Transmit_Start,
  output logic [$clog2(NUM_REQ)-1:0]   Grant_Id,
  output logic                         Active,
  output logic                         Timeout_Err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, rr_req;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [IW-1:0] grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, rr_win, win_id, next_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ts_q, ts_d, active_q, active_d, to_q, to_d, pri0, keep_ptr;
`ifdef UART_ARB_PRIORITY_EN
  assign rr_req   = {Req[NUM_REQ-1:1], 1'b0};
  assign pri0     = Req[0];
  assign keep_ptr = grant_id_q == '0;
`else
  assign rr_req   = Req;
  assign pri0     = 1'b0;
  assign keep_ptr = 1'b0;
`endif
  function automatic int wrap(input int v);
    return v >= NUM_REQ ? v - NUM_REQ : v;
  endfunction
  // Nearest set request at or above rr_ptr; scanning downward lets the closest one win
  always_comb begin
    rr_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rr_req[wrap(int'(rr_ptr_q) + i)]) rr_win = IW'(wrap(int'(rr_ptr_q) + i));
  end
  assign win_id   = pri0 ? '0 : rr_win;
  assign next_ptr = grant_id_q == IW'(NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    ts_d       = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      IDLE: if (|Req && !Tx_Busy && !BIST_Busy) begin
        state_d    = START;
        ts_d       = 1'b1;
        cnt_d      = '0;
        grant_id_d = win_id;
        tx_data_d  = Req_Data[win_id*DATA_BITS +: DATA_BITS];
      end
      START: if (Tx_Busy) begin
        state_d           = WAIT_DONE;
        ack_d[grant_id_q] = 1'b1;
        rr_ptr_d          = keep_ptr ? rr_ptr_q : next_ptr;
      end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
        state_d  = IDLE;
        to_d     = 1'b1;
        rr_ptr_d = keep_ptr ? rr_ptr_q : next_ptr;
      end else begin
        ts_d  = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
      WAIT_DONE: state_d = Tx_Busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
    active_d = state_d != IDLE;
  end
  // State and output registers
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      ts_q       <= 1'b0;
      active_q   <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      ts_q       <= ts_d;
      active_q   <= active_d;
      to_q       <= to_d;
    end
  end
  assign Ack            = ack_q;
  assign Tx_Data        = tx_data_q;
  assign Grant_Id       = grant_id_q;
  assign Transmit_Start = ts_q;
  assign Active         = active_q;
  assign Timeout_Err    = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple UART responder
module tb_uart_tx_arbiter;
  logic SysClk = 1'b0, Rst = 1'b1;
  logic [3:0] Req = '0, Ack;
  logic [31:0] Req_Data = '0;
  logic Tx_Busy = 1'b0, BIST_Busy = 1'b0, Transmit_Start, Active, Timeout_Err;
  logic [7:0] Tx_Data;
  logic [1:0] Grant_Id;
  typedef struct {int id; logic [7:0] data; bit to; int ts_len;} exp_t;
  exp_t sb[$];
  exp_t e;
  int vecs = 0, miss = 0, ts_run = 0, n;
  bit prev_ts = 1'b0, uart_dead = 1'b0;
  int ts_cnt = 0, busy_cnt = 0;
  localparam int RESP_DELAY = 2, BUSY_LEN = 3;

  uart_tx_arbiter dut (
    .SysClk(SysClk), .Rst(Rst), .Req(Req), .Req_Data(Req_Data), .Ack(Ack),
    .Tx_Busy(Tx_Busy), .BIST_Busy(BIST_Busy), .Tx_Data(Tx_Data),
    .Transmit_Start(Transmit_Start), .Grant_Id(Grant_Id), .Active(Active),
    .Timeout_Err(Timeout_Err)
  );

  always #5 SysClk = ~SysClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_grant(input int id, input bit to, input int ts_len);
    exp_t r;
    r.id = id; r.data = Req_Data[id*8 +: 8]; r.to = to; r.ts_len = ts_len;
    sb.push_back(r);
  endtask

  // sel: 0 = Ack pulse, 1 = Timeout_Err pulse, 2 = Transmit_Start high
  task automatic wait_for(input int sel, input string name);
    bit hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge SysClk);
      hit = sel == 0 ? Ack != 0 : sel == 1 ? Timeout_Err : Transmit_Start;
    end
    if (!hit) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(negedge SysClk);
    Rst = 1'b0;
  endtask

  // UART model: raises Tx_Busy after RESP_DELAY start cycles, holds it BUSY_LEN cycles
  initial forever begin
    @(negedge SysClk);
    if (Rst || uart_dead) begin
      Tx_Busy = 1'b0; ts_cnt = 0; busy_cnt = 0;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 0) Tx_Busy = 1'b0;
    end else if (Transmit_Start) begin
      ts_cnt++;
      if (ts_cnt == RESP_DELAY) begin
        Tx_Busy = 1'b1; busy_cnt = BUSY_LEN; ts_cnt = 0;
      end
    end else ts_cnt = 0;
  end

  // Monitor: every Ack or Timeout_Err pops the scoreboard and is checked against it
  initial forever begin
    @(negedge SysClk);
    if (Rst) ts_run = 0;
    else begin
      if (Transmit_Start) ts_run = prev_ts ? ts_run + 1 : 1;
      if (Ack != 0 || Timeout_Err) begin
        if (sb.size() == 0) chk("unexpected_event", {27'd0, Ack, Timeout_Err}, 0);
        else begin
          e = sb.pop_front();
          chk("timeout_flag", {31'd0, Timeout_Err}, {31'd0, e.to});
          chk("ack_vector", {28'd0, Ack}, e.to ? 32'd0 : 32'd1 << e.id);
          chk("grant_id", {30'd0, Grant_Id}, e.id);
          chk("tx_data", {24'd0, Tx_Data}, {24'd0, e.data});
          chk("start_len", ts_run, e.ts_len);
        end
      end
    end
    prev_ts = Transmit_Start;
  end

  initial begin
    do_reset();
    chk("rst_ack", {28'd0, Ack}, 0);
    chk("rst_ts", {31'd0, Transmit_Start}, 0);
    chk("rst_data", {24'd0, Tx_Data}, 0);
    chk("rst_gid", {30'd0, Grant_Id}, 0);
    chk("rst_active", {31'd0, Active}, 0);
    chk("rst_to", {31'd0, Timeout_Err}, 0);
    // single request
    Req_Data = 32'h0000_005A;
    expect_grant(0, 0, 2);
    Req = 4'b0001;
    wait_for(2, "t1_start");
    chk("t1_active", {31'd0, Active}, 1);
    chk("t1_data_at_start", {24'd0, Tx_Data}, 32'h5A);
    wait_for(0, "t1_ack");
    Req &= ~Ack;
    repeat (6) @(negedge SysClk);
    // all requesting continuously
    do_reset();
    Req_Data = {8'h43, 8'h32, 8'h21, 8'h10};
`ifdef UART_ARB_PRIORITY_EN
    for (int i = 0; i < 5; i++) expect_grant(0, 0, 2);
`else
    for (int i = 0; i < 5; i++) expect_grant(i % 4, 0, 2);
`endif
    Req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_for(0, "t2_ack");
    Req = 4'b0000;
    repeat (6) @(negedge SysClk);
    // dead transmitter: timeout, then rr_ptr must point at 3
    do_reset();
    uart_dead = 1'b1;
    expect_grant(2, 1, 64);
    Req = 4'b0100;
    wait_for(1, "t3_timeout");
    Req = 4'b0000;
    uart_dead = 1'b0;
    expect_grant(3, 0, 2);
    expect_grant(1, 0, 2);
    Req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      wait_for(0, "t3_ack");
      Req &= ~Ack;
    end
    repeat (6) @(negedge SysClk);
    // BIST ownership blocks grants
    do_reset();
    BIST_Busy = 1'b1;
    Req = 4'b0010;
    n = 0;
    repeat (100) begin
      @(negedge SysClk);
      if (Transmit_Start) n++;
    end
    chk("bist_blocked", n, 0);
    expect_grant(1, 0, 2);
    BIST_Busy = 1'b0;
    n = 0;
    while (!Transmit_Start && n < 10) begin
      @(negedge SysClk);
      n++;
    end
    chk("bist_release_fast", {31'd0, n >= 1 && n <= 2}, 1);
    wait_for(0, "t4_ack");
    Req &= ~Ack;
    repeat (6) @(negedge SysClk);
    // reset in the middle of START
    do_reset();
    uart_dead = 1'b1;
    Req_Data = {8'h43, 8'h32, 8'h21, 8'h10};
    Req = 4'b0100;
    wait_for(2, "t5_start");
    repeat (3) @(negedge SysClk);
    chk("t5_gid_before", {30'd0, Grant_Id}, 2);
    Rst = 1'b1;
    @(negedge SysClk);
    chk("t5_ts_after_rst", {31'd0, Transmit_Start}, 0);
    chk("t5_active_after_rst", {31'd0, Active}, 0);
    chk("t5_gid_after_rst", {30'd0, Grant_Id}, 0);
    chk("t5_data_after_rst", {24'd0, Tx_Data}, 0);
    uart_dead = 1'b0;
    expect_grant(2, 0, 2);
    Rst = 1'b0;
    wait_for(0, "t5_ack");
    Req &= ~Ack;
    repeat (6) @(negedge SysClk);
    // requester 0 arrives while 1 is in WAIT_DONE
    do_reset();
    Req_Data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    expect_grant(1, 0, 2);
`ifdef UART_ARB_PRIORITY_EN
    expect_grant(0, 0, 2);
    expect_grant(3, 0, 2);
`else
    expect_grant(3, 0, 2);
    expect_grant(0, 0, 2);
`endif
    Req = 4'b1010;
    wait_for(0, "t6_ack");
    Req = (Req & ~Ack) | 4'b0001;
    for (int i = 0; i < 2; i++) begin
      wait_for(0, "t6_ack");
      Req &= ~Ack;
    end
    repeat (10) @(negedge SysClk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_ack_idle", {28'd0, Ack}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `NUM_REQ` requesters. It sits in the `SysClk` domain in front of the UART's `Tx_Data`/`Transmit_Start` inputs. It latches the winning requester's byte and holds `Transmit_Start` until the transmitter reports `Tx_Busy`, then acknowledges the requester. The BIST owns the transmitter while `BIST_Busy` is high. A start-handshake timeout prevents a dead transmitter from locking the bus.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_BITS`, 8, UART data width
- `START_TIMEOUT`, 64, `SysClk` cycles allowed between `Transmit_Start` rise and `Tx_Busy` rise

Ports:
- `SysClk` in 1: system clock; the only clock in the block
- `Rst` in 1: reset; synchronous, active-high
- `Req` in `NUM_REQ`: per-requester level request; held until `Ack`
- `Req_Data` in `NUM_REQ*DATA_BITS`: requester i's byte at `[i*DATA_BITS +: DATA_BITS]`; stable while `Req[i]` is high
- `Ack` out `NUM_REQ`: one-cycle pulse marking the granted requester's byte as accepted by the transmitter
- `Tx_Busy` in 1: transmitter busy, from the UART
- `BIST_Busy` in 1: BIST owns the transmitter; no new grants while high
- `Tx_Data` out `DATA_BITS`: latched byte to the UART
- `Transmit_Start` out 1: start strobe to the UART
- `Grant_Id` out `$clog2(NUM_REQ)`: index of the current or last grant
- `Active` out 1: high in any state other than IDLE
- `Timeout_Err` out 1: one-cycle pulse on start-handshake timeout

## Operation
- States: IDLE, START, WAIT_DONE.
- **IDLE**
  - Grant when `|Req`, `!Tx_Busy` and `!BIST_Busy` are all true.
  - The winner is the first set `Req` bit searching upward from `rr_ptr`, wrapping at `NUM_REQ-1` to 0.
  - On grant: latch `Req_Data` slice into `Tx_Data`, set `Grant_Id`, go to START.
- **START**
  - `Transmit_Start`=1; timeout counter increments each cycle.
  - `Tx_Busy` sampled high: `Transmit_Start`←0, `Ack[Grant_Id]`←1 for one cycle, `rr_ptr`←`Grant_Id+1` (mod `NUM_REQ`), go to WAIT_DONE.
  - Counter reaches `START_TIMEOUT-1` with no `Tx_Busy`: `Transmit_Start`←0, `Timeout_Err` pulses, no `Ack`, `rr_ptr`←`Grant_Id+1`, go to IDLE.
- **WAIT_DONE**
  - Remain until `Tx_Busy` is sampled low, then go to IDLE.
- Requester drops `Req` during START or WAIT_DONE: ignored. The latched byte is still sent and `Ack` still pulses.
- `BIST_Busy` rising during START or WAIT_DONE: the in-flight transfer completes normally. It only blocks the next grant.
- A requester whose `Req` remains high after `Ack` is treated as a new request and competes again.
- Counter width is `$clog2(START_TIMEOUT)+1`. It clears on every entry to START.

## Timing
- All outputs are registered.
- Reset values:
  - `Ack`=0, `Transmit_Start`=0, `Tx_Data`=0, `Grant_Id`=0
  - `Active`=0, `Timeout_Err`=0
  - `rr_ptr`=0, state=IDLE
- Latency:
  - Grant conditions true at edge n → `Transmit_Start`=1 and `Tx_Data` valid from edge n+1.
  - `Tx_Busy` sampled high at edge m → `Ack` high and `Transmit_Start` low for the cycle after edge m.
- Minimum start handshake is 1 cycle. Back-to-back grants are separated by at least one IDLE cycle.
- `Rst` asserted in any state: all outputs take reset values at the next edge and any in-flight `Transmit_Start` is dropped. The UART must be reset concurrently.
- Simultaneous `Tx_Busy` rise and timeout terminal count in START: `Tx_Busy` wins, giving `Ack` and no `Timeout_Err`.

## Configuration
- `UART_ARB_PRIORITY_EN`
  - Defined: requester 0 has fixed top priority. If `Req[0]` is high in IDLE it wins regardless of `rr_ptr`. Remaining requesters are round-robin among themselves, and a grant to 0 does not move `rr_ptr`.
  - Undefined: pure round-robin as described above.

## Test plan
- Reset, then `Req`=4'b0001 with byte 0x5A, UART responds `Tx_Busy` 2 cycles after start → `Tx_Data`=0x5A, `Transmit_Start` high 2 cycles, `Ack`=4'b0001 single pulse, `Grant_Id`=0.
- `Req`=4'b1111 held continuously, bytes 0x10/0x21/0x32/0x43 → grant order 0,1,2,3,0 (macro off); `Ack` never on two bits at once.
- `Tx_Busy` tied low, `Req`=4'b0100 → `Transmit_Start` high exactly 64 cycles, `Timeout_Err` one pulse, no `Ack`, `rr_ptr`=3.
- `BIST_Busy`=1 with `Req`=4'b0010 for 100 cycles → no `Transmit_Start`; drop `BIST_Busy` → grant to 1 within 2 cycles.
- `Rst` pulsed mid-START with requester 2 granted → next cycle `Transmit_Start`=0, `Active`=0, `Grant_Id`=0; still-pending request re-granted after reset.
- Macro on, `Req`=4'b1010 then `Req[0]` rises while 1 is in WAIT_DONE → next grant to 0, then 3.
